// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register word offsets, CTRL field positions and mode encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Word offsets, compared against addr[3:2]
    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned MODE_MSB = 2;
    localparam int unsigned IM_BIT   = 3;

    localparam logic [1:0]  MODE_ONESHOT = 2'b00;
    localparam logic [1:0]  MODE_RELOAD  = 2'b01;
    localparam logic [31:0] CTRL_MASK    = 32'h0000_000F;

endpackage

// File: rtl/timer_unit_byte_merge.sv
// Combinational merge of an old word with new data under per-byte enables.
module byte_merge #(
    parameter int W = 32
) (
    input  logic [W-1:0]   old_word,
    input  logic [W-1:0]   new_word,
    input  logic [W/8-1:0] byteen,
    output logic [W-1:0]   merged
);

    // Select each byte lane from the new word when its enable is set
    always_comb begin
        merged = old_word;
        for (int i = 0; i < W/8; i++) begin
            if (byteen[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Countdown timer on the core's data port: CTRL/PRESET/COUNT registers,
// zero-latency reads and an expiry interrupt (one-shot or auto-reload).
module timer_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    state_e             state_q, state_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q, flag_d;
    logic               irq_q, irq_d;

    logic [1:0]  sel_s;
    logic        hit_s, wr_ctrl_s, wr_preset_s;
    logic        flag_set_s, flag_clr_s;
    logic [31:0] merge_old_s, merge_new_s;
    logic        addr_unused_s;

    assign sel_s         = addr[3:2];
    assign addr_unused_s = ^addr[1:0];
    assign hit_s         = (addr[31:4] == BASE_ADDR[31:4]) && (sel_s != 2'b11);
    assign wr_ctrl_s     = hit_s && (|byteen) && (sel_s == CTRL_OFF);
    assign wr_preset_s   = hit_s && (|byteen) && (sel_s == PRESET_OFF);
    assign merge_old_s   = (sel_s == PRESET_OFF) ? preset_q : ctrl_q;

    byte_merge #(.W(32)) u_merge (
        .old_word (merge_old_s),
        .new_word (wdata),
        .byteen   (byteen),
        .merged   (merge_new_s)
    );

    // Next-state: FSM, register writes and the expiry flag
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        flag_set_s = 1'b0;
        flag_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[EN_BIT]) state_d = ST_LOAD;
                else                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (ctrl_q[EN_BIT]) begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!ctrl_q[EN_BIT]) begin
                    state_d = ST_IDLE;
                end else if (count_q == {CNT_W{1'b0}}) begin
                    state_d    = ST_INT;
                    flag_set_s = 1'b1;
                end else begin
                    count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                // Reserved modes behave as one-shot; the flag is re-asserted so a
                // same-cycle software clear cannot swallow the expiry.
                if (ctrl_q[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
                    flag_clr_s = 1'b1;
                end else begin
                    ctrl_d[EN_BIT] = 1'b0;
                    flag_set_s     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ctrl_s) ctrl_d = merge_new_s & CTRL_MASK;
        else           ctrl_d = ctrl_d;
        if (wr_preset_s) preset_d = merge_new_s;
        else             preset_d = preset_q;

        if (flag_set_s)                                    flag_d = 1'b1;
        else if (flag_clr_s || wr_ctrl_s || wr_preset_s)   flag_d = 1'b0;
        else                                               flag_d = flag_q;

        irq_d = ctrl_d[IM_BIT] & flag_d;
    end

    // State and register update with asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 32'h0000_0000;
            preset_q <= {CNT_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit_s) begin
            case (sel_s)
                CTRL_OFF:   rdata = ctrl_q;
                PRESET_OFF: rdata = preset_q;
                COUNT_OFF:  rdata = count_q;
                default:    rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign hit = hit_s;
    assign irq = irq_q;

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: reset, one-shot, auto-reload, byte writes,
// disable/re-enable, INT-cycle collision and asynchronous mid-cycle reset.
module tb_timer_unit;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    timer_unit #(.BASE_ADDR(32'h0000_7F00), .CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byteen = be;
        cyc();
        byteen = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = a;
        #1;
        chk(tag, rdata, exp_q.pop_front());
    endtask

    task automatic irq_is(input string tag, input logic exp);
        exp_q.push_back({31'b0, exp});
        chk(tag, {31'b0, irq}, exp_q.pop_front());
    endtask

    task automatic hit_is(input string tag, input logic [31:0] a, input logic exp);
        exp_q.push_back({31'b0, exp});
        addr = a;
        #1;
        chk(tag, {31'b0, hit}, exp_q.pop_front());
    endtask

    initial begin
        #2 reset = 1'b0;
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_cnt", A_CNT, 32'h0);
        irq_is("rst_irq", 1'b0);
        @(negedge clk) reset = 1'b1;
        cyc();

        // One-shot, PRESET=3
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        cyc(); cyc();
        rd("os_cnt3", A_CNT, 32'd3);
        for (int k = 2; k >= 0; k--) begin
            cyc();
            rd("os_cnt", A_CNT, k[31:0]);
        end
        irq_is("os_irq_pre", 1'b0);
        cyc();
        irq_is("os_irq", 1'b1);
        cyc();
        rd("os_ctrl", A_CTRL, 32'h8);
        for (int k = 0; k < 10; k++) begin
            cyc();
            irq_is("os_hold", 1'b1);
        end
        wr(A_CTRL, 32'h8, 4'hF);
        irq_is("os_clear", 1'b0);

        // Auto-reload, PRESET=2: pulses 5, 11, 17 cycles after enable
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 18; k++) begin
            cyc();
            irq_is("ar_irq", (k == 5) || (k == 11) || (k == 17));
        end
        wr(A_CTRL, 32'h3, 4'hF);
        rd("ar_cnt0", A_CNT, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            int ph;
            cyc();
            ph = (k - 1) % 6;
            rd("ar_cnt", A_CNT, (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0);
            irq_is("ar_noirq", 1'b0);
        end
        wr(A_CTRL, 32'h0, 4'hF);
        cyc(); cyc();

        // Byte writes, read-only COUNT, decode
        wr(A_PRE, 32'h1122_3344, 4'hF);
        wr(A_PRE, 32'h00AA_0000, 4'b0100);
        rd("be_pre", A_PRE, 32'h11AA_3344);
        rd("be_pre_lo", BASE + 32'h6, 32'h11AA_3344);
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        rd("cnt_ro", A_CNT, 32'd2);
        wr(A_CTRL, 32'hFFFF_FFFE, 4'hF);
        rd("ctrl_mask", A_CTRL, 32'h0000_000E);
        wr(A_CTRL, 32'h0, 4'hF);
        hit_is("rsv_hit", A_RSV, 1'b0);
        rd("rsv_rd", A_RSV, 32'h0);
        hit_is("out_hit", 32'h0000_8000, 1'b0);
        hit_is("pre_hit", A_PRE, 1'b1);

        // Disable mid-count, then re-enable
        wr(A_PRE, 32'd100, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        repeat (52) cyc();
        rd("dis_cnt50", A_CNT, 32'd50);
        wr(A_CTRL, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            cyc();
            rd("dis_frozen", A_CNT, 32'd49);
            irq_is("dis_noirq", 1'b0);
        end
        wr(A_CTRL, 32'h9, 4'hF);
        cyc();
        rd("re_cnt_hold", A_CNT, 32'd49);
        cyc();
        rd("re_load", A_CNT, 32'd100);
        cyc();
        rd("re_dec", A_CNT, 32'd99);

        // Collision: CTRL write in the INT cycle
        repeat (100) cyc();
        irq_is("col_int_irq", 1'b1);
        rd("col_int_cnt", A_CNT, 32'd0);
        wr(A_CTRL, 32'h9, 4'hF);
        rd("col_ctrl", A_CTRL, 32'h9);
        irq_is("col_irq", 1'b1);
        cyc(); cyc();
        rd("col_reload", A_CNT, 32'd100);
        irq_is("col_irq_hold", 1'b1);

        // Asynchronous reset between edges
        #1 reset = 1'b0;
        rd("arst_ctrl", A_CTRL, 32'h0);
        rd("arst_pre", A_PRE, 32'h0);
        rd("arst_cnt", A_CNT, 32'h0);
        irq_is("arst_irq", 1'b0);
        @(negedge clk) reset = 1'b1;
        cyc(); cyc();
        rd("post_rst_cnt", A_CNT, 32'h0);
        irq_is("post_rst_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Memory-mapped countdown timer on the CPU data port. It consumes the data-side bus the pipeline core drives from its MEM stage: byte address, write data and byte enables.
- It returns read data in the same cycle, matching the core's combinational load path.
- It raises an interrupt request when the count expires. This is the first data-side peripheral behind the core, ahead of a full system bridge.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base address; the block decodes a 16-byte window.
- CNT_W, 32, width of the PRESET and COUNT registers (fixed at 32 in this revision).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from the core's data port (m_data_addr).
- wdata  input  32  store data, already byte-lane aligned (m_data_wdata).
- byteen  input  4  byte write enables; all zero means no write (m_data_byteen).
- rdata  output  32  read data for the addressed register; combinational.
- hit  output  1  addr falls in a valid register slot of this block.
- irq  output  1  interrupt request to the core.

Behaviour:
- Register map, offset from BASE_ADDR:
  - +0x0 CTRL, R/W: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0 and ignore writes.
  - +0x4 PRESET, R/W.
  - +0x8 COUNT, read-only; writes are ignored.
  - +0xC reserved: hit=0, rdata=0.
- Decode: hit = (addr[31:4]==BASE_ADDR[31:4]) && (addr[3:2]!=2'b11). Address bits [1:0] are ignored.
- Write: occurs when hit && |byteen. Only the enabled bytes update; other bytes hold.
- Read: rdata = the selected register when hit, else 32'h0. Zero-cycle latency.
- Reset (reset low, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, flag=0, irq=0, rdata=0.
- A reset asserted mid-count aborts immediately. No interrupt is issued.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT<=PRESET; -> CNT. If EN=0 -> IDLE without loading.
  - CNT:
    - EN=0 -> IDLE, COUNT frozen.
    - Else if COUNT==0 -> INT and flag<=1.
    - Else COUNT<=COUNT-1.
  - INT:
    - MODE 2'b00 (one-shot), or reserved 2'b10/2'b11: EN<=0, -> IDLE, flag stays 1.
    - MODE 2'b01 (auto-reload): -> IDLE with EN kept, so it reloads; flag<=0 on leaving INT.
- irq = IM & flag.
  - One-shot: irq is level and holds until software writes CTRL or PRESET; any such write clears flag that cycle.
  - Auto-reload: irq is a one-cycle pulse for each expiry.
- Period, auto-reload: PRESET+4 cycles per expiry (IDLE, LOAD, PRESET+1 CNT cycles, INT).
- PRESET=0: expires after one CNT cycle.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as INT's EN<=0: the CPU write wins.
  - A write to PRESET during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - A flag clear by write and a new expiry in the same cycle: the set wins.
- COUNT never wraps: it stops at 0.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE/LOAD/CNT/INT);
  - register offsets CTRL_OFF/PRESET_OFF/COUNT_OFF;
  - CTRL bit indices EN_BIT, MODE_LSB/MODE_MSB, IM_BIT;
  - mode constants MODE_ONESHOT and MODE_RELOAD.
- One sub-module, byte_merge: combinational old/new word merge under byteen. It is reused by future peripherals.
- All other logic stays in timer_unit.

Test Plan:
- Reset. Pull reset low mid-cycle with no clock edge -> rdata of CTRL/PRESET/COUNT reads 0 and irq=0 immediately.
- One-shot:
  - Stimulus: write PRESET=3, then write CTRL=32'h9 at edge t.
  - Required: COUNT=3 after t+2; COUNT=2,1,0 after t+3..t+5; irq=1 after t+6; CTRL reads 32'h8 after t+7.
  - irq stays 1 for 10 further idle cycles. Writing CTRL=32'h8 drops irq next edge.
- Auto-reload: PRESET=2, CTRL=32'hB -> irq pulses exactly one cycle every 6 cycles, 3 pulses observed. With IM=0 (CTRL=32'h3) irq stays 0 while COUNT still cycles.
- Byte writes:
  - PRESET=32'h1122_3344, then byteen=4'b0100 with wdata=32'h00AA_0000 -> PRESET reads 32'h11AA_3344.
  - A write to COUNT with byteen=4'hF is ignored.
  - addr=BASE+0xC -> hit=0, rdata=0.
- Disable mid-count: PRESET=100, count to 50, write CTRL=0 -> COUNT frozen at its value, no irq.
- Re-enable: CTRL=32'h9 -> reload from 100 via LOAD.
- Collision: write CTRL=32'h9 in the INT cycle of a one-shot -> EN reads 1 afterwards and the timer reloads. The flag was cleared by the write but set by the expiry in the same cycle, so irq=1.
